// File: rtl/rr_pkg.sv
// rtl/rr_pkg.sv - shared round-robin pick function, FIFO depth and count type
package rr_pkg;

  localparam int RR_MAX_W   = 32;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] fifo_count_t;

  // One-hot pick of the first req bit at or after rotl(last_onehot), wrapping within n bits.
  // The double-width subtract clears exactly the lowest req bit at or above start.
  function automatic logic [RR_MAX_W-1:0] rr_pick(
    input logic [RR_MAX_W-1:0] req,
    input logic [RR_MAX_W-1:0] last_onehot,
    input int unsigned         n
  );
    logic [RR_MAX_W-1:0]   mask;
    logic [RR_MAX_W-1:0]   start;
    logic [2*RR_MAX_W-1:0] dbl;
    logic [2*RR_MAX_W-1:0] diff;
    logic [2*RR_MAX_W-1:0] hit;
    mask  = (n >= RR_MAX_W) ? '1 : ((RR_MAX_W'(1) << n) - RR_MAX_W'(1));
    start = ((last_onehot << 1) | (last_onehot >> (n - 1))) & mask;
    dbl   = {RR_MAX_W'(0), req & mask} | ({RR_MAX_W'(0), req & mask} << n);
    diff  = dbl - {RR_MAX_W'(0), start};
    hit   = dbl & ~diff;
    return (hit[RR_MAX_W-1:0] | RR_MAX_W'(hit >> n)) & mask;
  endfunction

endpackage

// File: rtl/rr_dispatch_fifo.sv
// rtl/rr_dispatch_fifo.sv - 2-entry input FIFO with registered count and registered push_ready
module rr_dispatch_fifo
  import rr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          not_empty
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  fifo_count_t   count;
  fifo_count_t   count_next;
  logic          push;

  assign push = push_valid & push_ready;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + fifo_count_t'(1);
    end else if (pop && !push) begin
      count_next = count - fifo_count_t'(1);
    end
  end

  // push_ready is kept as its own flop so it never depends on this cycle's inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      push_ready <= 1'b1;
    end else begin
      count      <= count_next;
      push_ready <= (count_next != fifo_count_t'(FIFO_DEPTH));
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign not_empty = (count != '0);

endmodule

// File: rtl/round_robin_dispatch.sv
// rtl/round_robin_dispatch.sv - one-to-WIDTH rotating work dispatcher with per-channel slots
// RR_DISPATCH_STRICT_EN: strict rotation (stall on a busy channel instead of skipping it).
module round_robin_dispatch
  import rr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic [WIDTH-1:0]    out_valid,
  input  logic [WIDTH-1:0]    out_ready,
  output logic [WIDTH*DW-1:0] out_data,
  output logic [WIDTH-1:0]    dispatch_onehot
);

  logic [WIDTH-1:0] last_served;
  logic [WIDTH-1:0] elig;
  logic [WIDTH-1:0] pick;
  logic [DW-1:0]    head_data;
  logic             fifo_not_empty;
  logic             dispatch;

  rr_dispatch_fifo #(.DW(DW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_data),
    .pop        (dispatch),
    .head_data  (head_data),
    .not_empty  (fifo_not_empty)
  );

  // A slot draining this cycle can be refilled at the same edge.
  assign elig = ~out_valid | out_ready;

`ifdef RR_DISPATCH_STRICT_EN
  logic [WIDTH-1:0] start;
  assign start = {last_served[WIDTH-2:0], last_served[WIDTH-1]};
  assign pick  = start & elig;
`else
  logic [RR_MAX_W-1:0] pick_wide;
  logic                unused_pick_hi;
  assign pick_wide      = rr_pick(RR_MAX_W'(elig), RR_MAX_W'(last_served), WIDTH);
  assign pick           = pick_wide[WIDTH-1:0];
  assign unused_pick_hi = ^pick_wide[RR_MAX_W-1:WIDTH];
`endif

  assign dispatch        = fifo_not_empty & (|pick);
  assign dispatch_onehot = dispatch ? pick : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= '0;
      out_data    <= '0;
      last_served <= WIDTH'(1) << (WIDTH - 1);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (dispatch_onehot[i]) begin
          out_valid[i]           <= 1'b1;
          out_data[i*DW +: DW]   <= head_data;
        end else if (out_ready[i]) begin
          out_valid[i]           <= 1'b0;
        end
      end
      if (dispatch) last_served <= pick;
    end
  end

endmodule

// File: doc/round_robin_dispatch.md
Name: round_robin_dispatch

Overview:
- One-to-N work distributor: the complement of the round-robin request arbiter. It takes a single valid/ready input stream and hands each item to one of WIDTH consumer channels in rotating order.
- A 2-entry input FIFO decouples in_ready from the consumers.
- A one-deep registered slot per channel holds the dispatched item until that consumer accepts it.
- Sits between a shared producer and replicated worker units.

Parameters:
- WIDTH, 4: number of output channels; must be >= 2.
- DW, 8: data width of one item.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer item valid.
- in_ready  output  1  FIFO can accept; registered (not combinationally dependent on in_valid or out_ready).
- in_data  input  DW  producer item.
- out_valid  output  WIDTH  per-channel slot holds an item.
- out_ready  input  WIDTH  per-channel consumer accept.
- out_data  output  WIDTH*DW  channel i occupies bits [i*DW +: DW].
- dispatch_onehot  output  WIDTH  one-hot channel loaded at the coming edge; 0 when no dispatch.

Behaviour:
- Handshakes:
  - Input transfer when in_valid & in_ready at a rising edge.
  - Output transfer on channel i when out_valid[i] & out_ready[i].
  - in_data must be held stable while in_valid & !in_ready.
- Input FIFO:
  - 2 entries with a registered count 0..2; in_ready = (count != 2).
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: an item accepted at edge T can reach a slot no earlier than edge T+1, so minimum latency in->out_valid is 2 edges.
- Channel eligibility: elig[i] = !out_valid[i] | out_ready[i]. A slot being drained this cycle may be reloaded at the same edge.
- Dispatch pick:
  - last_served is one-hot and resets to 1<<(WIDTH-1), so channel 0 is first after reset.
  - start = last_served rotated left by 1.
  - Pick = first elig bit at or after start, searching upward with wrap from bit WIDTH-1 to bit 0. Use the double-width subtract/mask method on {elig,elig}.
- Dispatch occurs when FIFO count != 0 and |elig. Then:
  - dispatch_onehot = pick.
  - At the edge: FIFO pops, slot[pick] loads the head item, out_valid[pick] is set, last_served <= pick.
  - Otherwise dispatch_onehot = 0 and last_served holds.
- Slot update: out_valid[i] clears on output transfer unless reloaded at the same edge. Only out_data[pick] changes.
- Reset, including assertion mid-operation:
  - out_valid = 0, out_data = 0, FIFO count = 0 (contents discarded), in_ready = 1 after release, last_served = 1<<(WIDTH-1), dispatch_onehot = 0.
- No dropped or duplicated items. Per-channel order is preserved. Global order equals dispatch order.

Optional Feature:
- Macro: RR_DISPATCH_STRICT_EN.
- Defined: strict rotation. The only candidate is start itself. If channel start is not eligible, dispatch stalls and no other channel is loaded. Channels therefore receive items exactly in the sequence 0,1,..,WIDTH-1,0,...
- Undefined: work-conserving pick as described above; busy channels are skipped.

Decomposition:
- Package rr_pkg:
  - Function rr_pick(req, last_onehot) returning the one-hot pick. Reusable by the arbiter.
  - Localparam FIFO_DEPTH = 2.
  - Typedef for the 2-bit FIFO count.
- Sub-module rr_dispatch_fifo: the 2-entry FIFO with registered count and in_ready.

Test Plan:
- Reset, all out_ready = 1, push items 0xA0..0xA7 back-to-back. Expect:
  - In_valid high from cycle 0; first out_valid[0] appears after edge 2.
  - Channels get 0xA0→ch0, 0xA1→ch1, 0xA2→ch2, 0xA3→ch3, 0xA4→ch0, …
  - in_ready stays 1.
- Hold out_ready[1] = 0 after ch1 is loaded, keep pushing. Expect:
  - Default build: ch1 skipped; order ch2, ch3, ch0, ch2 …
  - With RR_DISPATCH_STRICT_EN: dispatch stalls at ch1; FIFO fills to 2; in_ready = 0 until out_ready[1] = 1.
- All out_ready = 0 with slots full, push 3 items. Expect:
  - 2 accepted, then in_ready = 0, dispatch_onehot = 0.
  - Raise out_ready[3]: next item goes to ch3 at the same edge ch3 drains.
- Wrap check with last_served = ch3, only ch3 and ch1 eligible. Expect pick = ch1 (wrap past ch3; ch0 not eligible).
- Assert rst_n mid-stream with FIFO count = 2 and 3 slots valid. Expect:
  - Immediately out_valid = 0 and dispatch_onehot = 0.
  - After release, the first pushed item goes to ch0.
- Random stimulus for 10k cycles with a scoreboard. Expect no loss or duplication, and per-channel order preserved.
